// File: rtl/bit7_mux_arbiter.sv
// Round-robin arbiter and sequencer for two requesters that share one 7-bit
// datapath. The arbiter drives the select of the 2:1 mux cell. It grants
// ownership for bursts and registers the selected beat onto an output channel
// that has valid/ready back-pressure. Port 0 feeds op1 (sel=1) and port 1
// feeds op2 (sel=0).

// 7-bit 2:1 mux cell: sl=1 passes op1, sl=0 passes op2.
module bit7_2_1_mux (
  input  logic [6:0] op1,
  input  logic [6:0] op2,
  input  logic       sl,
  output logic [6:0] y
);

  assign y = sl ? op1 : op2;

endmodule

module bit7_mux_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [6:0] data0,
  input  logic       last0,
  output logic       ack0,
  input  logic       req1,
  input  logic [6:0] data1,
  input  logic       last1,
  output logic       ack1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       sel,
  output logic [6:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Last beat index an owner may reach before it must yield to a waiting peer.
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       rr_last_q, rr_last_d;
  logic [6:0] out_data_q, out_data_d;
  logic       out_last_q, out_last_d;
  logic       out_valid_q, out_valid_d;

  logic [6:0] mux_y;
  logic       accept;
  logic       own_req;
  logic       own_last;
  logic       own_ack;
  logic       other_req;
  logic       release_own;

  // Grants and select are pure decodes of the registered state. In IDLE the
  // select rests on port 0.
  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign sel  = (state_q != OWN1);

  // The output register can take a new beat when it is empty or is draining.
  assign accept = !out_valid_q || out_ready;

  assign ack0 = rst_n && gnt0 && req0 && accept;
  assign ack1 = rst_n && gnt1 && req1 && accept;

  bit7_2_1_mux u_mux (
    .op1 (data0),
    .op2 (data1),
    .sl  (sel),
    .y   (mux_y)
  );

  // Owner and peer views. These are only meaningful in OWN0/OWN1.
  assign own_req   = sel ? req0  : req1;
  assign own_last  = sel ? last0 : last1;
  assign other_req = sel ? req1  : req0;
  assign own_ack   = ack0 || ack1;

  // Release on the owner's last beat, on a forced yield at the burst limit
  // while the peer waits, or as soon as the owner drops its request.
  assign release_own = !own_req ||
                       (own_ack && (own_last ||
                                    ((beat_cnt_q == BURST_LIMIT) && other_req)));

  // Next-state logic for arbitration, burst counting and the output register.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rr_last_d   = rr_last_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (own_ack) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      out_last_d  = own_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // On a tie, the port that was not served last wins.
        if (req0 && (!req1 || rr_last_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (release_own) begin
          rr_last_d  = (state_q == OWN1);
          beat_cnt_d = 8'd0;
          if (other_req) begin
            state_d = (state_q == OWN0) ? OWN1 : OWN0;
          end else begin
            state_d = IDLE;
          end
        end else if (own_ack && (beat_cnt_q != BURST_LIMIT)) begin
          // Saturate at the limit so a lone owner keeps streaming.
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= 8'd0;
      rr_last_q   <= 1'b1;
      out_data_q  <= 7'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      rr_last_q   <= rr_last_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bit7_mux_arbiter.sv
// Testbench for bit7_mux_arbiter. Directed scenarios run first, then a long
// randomized run. Every cycle is compared against a behavioural model of the
// arbitration rules.
module tb_bit7_mux_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, last0, ack0, req1, last1, ack1;
  logic [6:0] data0, data1;
  logic       gnt0, gnt1, sel;
  logic [6:0] out_data;
  logic       out_last, out_valid, out_ready;

  bit7_mux_arbiter #(.MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .last0     (last0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .last1     (last1),
    .ack1      (ack1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pending beats per source, as {last, data}. A source offers its front
  // beat until that beat is acknowledged. hold_i models abandoning a request.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         hold0 = 1'b0;
  bit         hold1 = 1'b0;
  bit         cap_ack0, cap_ack1;

  // Behavioural model: owner -1 means no owner. sent counts beats in the
  // current tenure, without bound.
  int         m_owner;
  int         m_sent;
  int         m_served;
  bit         m_ov;
  logic [6:0] m_od;
  bit         m_ol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner  = -1;
    m_sent   = 0;
    m_served = 1;
    m_ov     = 1'b0;
    m_od     = 7'd0;
    m_ol     = 1'b0;
  endfunction

  task automatic model_update();
    bit         r[2];
    bit         l[2];
    logic [6:0] d[2];
    bit         took;
    int         i;
    int         o;
    r[0] = req0; r[1] = req1;
    l[0] = last0; l[1] = last1;
    d[0] = data0; d[1] = data1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    took = (m_owner >= 0) && r[m_owner] && (!m_ov || out_ready);
    if (took) begin
      m_ov = 1'b1;
      m_od = d[m_owner];
      m_ol = l[m_owner];
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (m_owner < 0) begin
      if (r[0] && r[1]) m_owner = 1 - m_served;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
    end else begin
      i = m_owner;
      o = 1 - i;
      if (!r[i] || (took && (l[i] || ((m_sent + 1 >= MB) && r[o])))) begin
        m_served = i;
        m_sent   = 0;
        m_owner  = r[o] ? o : -1;
      end else if (took) begin
        m_sent++;
      end
    end
  endtask

  task automatic drive();
    req0  = (q0.size() > 0) && !hold0;
    data0 = (q0.size() > 0) ? q0[0][6:0] : 7'h00;
    last0 = (q0.size() > 0) ? q0[0][7]   : 1'b0;
    req1  = (q1.size() > 0) && !hold1;
    data1 = (q1.size() > 0) ? q1[0][6:0] : 7'h00;
    last1 = (q1.size() > 0) ? q1[0][7]   : 1'b0;
  endtask

  // One clock. Drive from the queues, compare against the model, cross the
  // edge, advance the model and retire acknowledged beats.
  task automatic step();
    bit acc;
    drive();
    #1;
    acc = !m_ov || out_ready;
    check("gnt0", gnt0, m_owner == 0);
    check("gnt1", gnt1, m_owner == 1);
    check("sel", sel, m_owner != 1);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_last", out_last, m_ol);
    check("ack0", ack0, rst_n && (m_owner == 0) && req0 && acc);
    check("ack1", ack1, rst_n && (m_owner == 1) && req1 && acc);
    cap_ack0 = ack0;
    cap_ack1 = ack1;
    @(posedge clk);
    model_update();
    if (cap_ack0 && q0.size() > 0) void'(q0.pop_front());
    if (cap_ack1 && q1.size() > 0) void'(q1.pop_front());
    @(negedge clk);
  endtask

  task automatic push_burst(input int port, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1), 7'($urandom)};
      if (port == 0) q0.push_back(b);
      else           q1.push_back(b);
    end
  endtask

  task automatic run_until_idle(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && !gnt0 && !gnt1 && !out_valid) done = 1'b1;
      else step();
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    int n0;
    bit seen1;
    bit prev;
    bit hit;
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset held with both ports requesting.
    q0.push_back(8'h81);
    q1.push_back(8'h82);
    step();
    step();
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_sel", sel, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ack0", cap_ack0, 1'b0);
    check("rst_ack1", cap_ack1, 1'b0);
    rst_n = 1'b1;
    step();
    check("first_gnt0", gnt0, 1'b1);
    check("first_sel", sel, 1'b1);
    run_until_idle("drain_reset");

    // Single three-beat burst from port 0.
    q0.push_back(8'h15);
    q0.push_back(8'h2A);
    q0.push_back(8'hFF);
    step();
    step();
    check("burst_ack_a", cap_ack0, 1'b1);
    check("burst_d0", out_data, 7'h15);
    step();
    check("burst_ack_b", cap_ack0, 1'b1);
    check("burst_d1", out_data, 7'h2A);
    step();
    check("burst_ack_c", cap_ack0, 1'b1);
    check("burst_d2", out_data, 7'h7F);
    check("burst_last", out_last, 1'b1);
    check("burst_idle", gnt0, 1'b0);
    run_until_idle("drain_burst");

    // Tie with single-beat bursts: grants alternate with no idle gap.
    for (int k = 0; k < 4; k++) begin
      push_burst(0, 1);
      push_burst(1, 1);
    end
    step();
    prev = gnt0;
    for (int k = 0; k < 7; k++) begin
      step();
      check("tie_handover", gnt0 ^ gnt1, 1'b1);
      check("tie_alt", gnt0, !prev);
      prev = gnt0;
    end
    run_until_idle("drain_tie");

    // Forced rotation: 8-beat burst on port 0 while port 1 waits.
    push_burst(0, 8);
    step();
    push_burst(1, 1);
    n0 = 0;
    seen1 = 1'b0;
    for (int k = 0; k < 30 && (q0.size() > 0 || q1.size() > 0); k++) begin
      step();
      if (cap_ack1 && !seen1) begin
        check("force_cnt", n0, MB);
        seen1 = 1'b1;
      end
      if (cap_ack0 && !seen1) n0++;
    end
    check("force_seen", seen1, 1'b1);
    check("force_resume", q0.size(), 0);
    run_until_idle("drain_force");

    // Back-pressure with 7'h33 sitting in the output register.
    q0.push_back(8'h11);
    q0.push_back(8'h33);
    q0.push_back(8'h44);
    q0.push_back(8'hD5);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      step();
      hit = out_valid && (out_data == 7'h33);
    end
    check("bp_reach", hit, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_hold_data", out_data, 7'h33);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_no_ack", cap_ack0, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check("bp_resume_ack", cap_ack0, 1'b1);
    check("bp_resume_data", out_data, 7'h44);
    run_until_idle("drain_bp");

    // Owner abandons mid-burst while the other port waits.
    push_burst(0, 5);
    step();
    push_burst(1, 2);
    step();
    step();
    hold0 = 1'b1;
    step();
    check("abandon_handover", gnt1, 1'b1);
    hold0 = 1'b0;
    run_until_idle("drain_abandon");

    // Owner abandons with no one else requesting.
    q0.push_back(8'h01);
    q0.push_back(8'h02);
    step();
    step();
    hold0 = 1'b1;
    step();
    check("abandon_idle0", gnt0, 1'b0);
    check("abandon_idle1", gnt1, 1'b0);
    q0.delete();
    hold0 = 1'b0;
    run_until_idle("drain_abandon_idle");

    // Reset while port 1 owns the datapath with a beat in the output register.
    q1.push_back(8'h5A);
    q1.push_back(8'h6B);
    q1.push_back(8'hFC);
    step();
    step();
    check("own1_gnt", gnt1, 1'b1);
    check("own1_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    step();
    check("midrst_gnt1", gnt1, 1'b0);
    check("midrst_sel", sel, 1'b1);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 7'h00);
    check("midrst_last", out_last, 1'b0);
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    step();

    // Randomized traffic, back-pressure, abandons and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) push_burst(0, $urandom_range(1, 7));
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) push_burst(1, $urandom_range(1, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      hold0 = ($urandom_range(0, 24) == 0);
      hold1 = ($urandom_range(0, 24) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
